fb_stream_scaler: RTL and testbench
===================================

# fb_stream_scaler

Frame-buffer readout streamer between the camera frame buffer and the SPI/OLED or FIFO sink. It scans a packed-RGB frame buffer through a synchronous read port and decimates the image by a power-of-two factor. Each fetched pixel is converted to RGB565 by MSB replication and emitted on a valid/ready stream that carries start-of-frame and end-of-line flags. It replaces ad-hoc address counters and bit slicing in the top level with one parametrised, backpressure-aware block.

## Interface
Parameters:
- `IMG_COLS`, 160, source image width in pixels
- `IMG_ROWS`, 120, source image height in pixels
- `ADDR_W`, 15, frame-buffer address width; must satisfy 2^ADDR_W ≥ IMG_COLS*IMG_ROWS
- `NB_R`, 4, red bits in a buffer word; range 1..5
- `NB_G`, 4, green bits in a buffer word; range 1..6
- `NB_B`, 4, blue bits in a buffer word; range 1..5
- `DECIM_LOG2`, 1, decimation shift; range 0..3; OUT_COLS = IMG_COLS>>DECIM_LOG2, OUT_ROWS = IMG_ROWS>>DECIM_LOG2

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: single-cycle request to stream one frame
- `busy` out 1: high from the cycle after an accepted start until the last beat is handshaken
- `frame_done` out 1: one-cycle pulse after the last handshake
- `fb_addr` out ADDR_W: frame-buffer read address; data is returned one cycle later
- `fb_data` in NB_R+NB_G+NB_B: buffer word packed {R,G,B} with R in the MSBs
- `m_valid` out 1: stream data valid
- `m_ready` in 1: sink ready
- `m_data` out 16: pixel packed {R5,G6,B5}
- `m_sof` out 1: qualifies the first beat of the frame
- `m_eol` out 1: qualifies the last beat of each output row

## Operation
- FSM states: IDLE, READ, LATCH, OUT.
  - IDLE: when `start`=1, clear out_col, out_row and row_base, then go to READ.
  - READ: drive `fb_addr` = row_base + (out_col<<DECIM_LOG2), then go to LATCH.
  - LATCH: register the converted `fb_data` into `m_data`, set `m_valid`, compute `m_sof`/`m_eol`, then go to OUT.
  - OUT: on `m_valid`&&`m_ready`, drop `m_valid` and advance the coordinates. If the beat was the last one, go to IDLE and pulse `frame_done`; otherwise go to READ.
- Coordinate advance: out_col+1. On a wrap at OUT_COLS, set out_col=0, out_row+1 and row_base += IMG_COLS<<DECIM_LOG2. No multiplier is used.
- `m_sof` = (out_col==0 && out_row==0).
- `m_eol` = (out_col==OUT_COLS-1).
- The last beat is the one where out_col==OUT_COLS-1 and out_row==OUT_ROWS-1.
- Colour conversion: each channel is widened to its target width (5/6/5) by repeating the source field MSB-first and truncating. With 4-bit fields, R5={r,r[3]}, G6={g,g[3:2]}, B5={b,b[3]}.
- `start` is ignored while `busy`=1.
- `m_data`, `m_sof` and `m_eol` hold stable while `m_valid`=1 and `m_ready`=0.
- When `m_valid`=0, `m_data`, `m_sof` and `m_eol` keep their last values and carry no meaning.
- Reset values: `busy`=0, `frame_done`=0, `fb_addr`=0, `m_valid`=0, `m_data`=0, `m_sof`=0, `m_eol`=0, FSM=IDLE.
- Reset asserted mid-frame aborts the frame immediately. No `frame_done` pulse is produced, and the next `start` begins again at address 0.

## Timing
- Cycle 0: `start` is sampled high.
- Cycle 1: READ; `fb_addr` is valid and `busy`=1.
- Cycle 2: LATCH; `fb_data` is valid.
- Cycle 3: `m_valid`=1.
- After a handshake in cycle k, the next `m_valid` rises in cycle k+3. Peak throughput is therefore 1 pixel per 3 clocks.
- `frame_done`=1 and `busy`=0 in the cycle after the final handshake.
- A new `start` is accepted in that same cycle.
- `fb_addr` is registered and changes only when entering READ.

## Configuration
- Macro: `FBS_TESTPAT_EN`.
- With the macro defined: an extra input `test_mode` (1 bit) is added.
  - While `test_mode`=1, `fb_data` is ignored and LATCH loads colour bars instead.
  - Bar index idx = out_col[5:3]. R5 = idx[2]?5'h1F:0, G6 = idx[1]?6'h3F:0, B5 = idx[0]?5'h1F:0.
  - Reads and timing are identical to normal mode.
- Without the macro: there is no `test_mode` port and the output is always converted buffer data.

## Test plan
- Frame scan, defaults (160x120, DECIM_LOG2=1), model fb_data = addr[11:0], m_ready=1:
  - exactly 4800 beats;
  - `fb_addr` sequence 0, 2, 4 … 158, then 320, 322 …;
  - `m_sof` on beat 0 only;
  - `m_eol` on beats 79, 159 … 4799;
  - a single `frame_done` one cycle after beat 4799.
- Conversion, fb_data held at each value:
  - 12'hF00 -> 16'hF800;
  - 12'h0F0 -> 16'h07E0;
  - 12'h00F -> 16'h001F;
  - 12'h8A5 -> 16'h8D4A.
- Backpressure: drop m_ready for 10 cycles while m_valid=1 -> `m_data`/`m_sof`/`m_eol` remain constant, no address advance, no beat lost or duplicated.
- Start during busy: pulse start at beat 100 -> ignored; the frame still has 4800 beats and one `frame_done`.
- Reset mid-frame at beat 1234 -> all outputs return to reset values; restarting gives first `fb_addr`=0 with `m_sof`=1.
- With FBS_TESTPAT_EN and test_mode=1:
  - beats 0–7 give 16'h0000;
  - beats 8–15 give 16'h001F;
  - beats 56–63 give 16'hFFFF;
  - read timing is unchanged.

Source files
------------

// File: rtl/fb_stream_scaler.sv
// fb_stream_scaler: scans a packed-RGB frame buffer through a synchronous
// read port, decimates by 2^DECIM_LOG2 and streams RGB565 beats.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            one-cycle frame request (ignored while busy)
//   busy             frame in progress
//   frame_done       one-cycle pulse after the final handshake
//   fb_addr          registered read address, data returns next cycle
//   fb_data          buffer word {R,G,B}, R in the MSBs
//   m_valid/m_ready  output stream handshake
//   m_data           pixel {R5,G6,B5}
//   m_sof            first beat of the frame
//   m_eol            last beat of each output row
//   test_mode        colour-bar source, present only with FBS_TESTPAT_EN
//
// Optional feature macro: FBS_TESTPAT_EN (adds test_mode colour bars).

module fb_stream_scaler #(
    parameter int IMG_COLS   = 160,
    parameter int IMG_ROWS   = 120,
    parameter int ADDR_W     = 15,
    parameter int NB_R       = 4,
    parameter int NB_G       = 4,
    parameter int NB_B       = 4,
    parameter int DECIM_LOG2 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     frame_done,
    output logic [ADDR_W-1:0]        fb_addr,
    input  logic [NB_R+NB_G+NB_B-1:0] fb_data,
    output logic                     m_valid,
    input  logic                     m_ready,
`ifdef FBS_TESTPAT_EN
    input  logic                     test_mode,
`endif
    output logic [15:0]              m_data,
    output logic                     m_sof,
    output logic                     m_eol
);

    localparam int DW       = NB_R + NB_G + NB_B;
    localparam int OUT_COLS = IMG_COLS >> DECIM_LOG2;
    localparam int OUT_ROWS = IMG_ROWS >> DECIM_LOG2;

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(OUT_COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(OUT_ROWS - 1);
    // One output row skips 2^DECIM_LOG2 source rows.
    localparam logic [ADDR_W-1:0] ROW_STEP =
        ADDR_W'(IMG_COLS << DECIM_LOG2);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LATCH,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] out_col_q, out_col_d;
    logic [ADDR_W-1:0] out_row_q, out_row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              m_valid_q, m_valid_d;
    logic [15:0]       m_data_q, m_data_d;
    logic              m_sof_q, m_sof_d;
    logic              m_eol_q, m_eol_d;

    // ------------------------------------------------------------
    // Colour conversion
    // ------------------------------------------------------------
    logic [NB_R-1:0] r_f;
    logic [NB_G-1:0] g_f;
    logic [NB_B-1:0] b_f;
    logic [4:0]      r5;
    logic [5:0]      g6;
    logic [4:0]      b5;
    logic [15:0]     pix;

`ifdef FBS_TESTPAT_EN
    logic [2:0] bar_idx;
    assign bar_idx = out_col_q[5:3];
`endif

    // Each target bit takes the source field MSB-first, wrapping back to
    // the MSB when the source is narrower than the target.
    always_comb begin
        r_f = fb_data[DW-1 -: NB_R];
        g_f = fb_data[NB_G+NB_B-1 -: NB_G];
        b_f = fb_data[NB_B-1:0];
        r5  = '0;
        g6  = '0;
        b5  = '0;
        for (int i = 0; i < 5; i++) begin
            r5[4-i] = r_f[NB_R-1-(i % NB_R)];
        end
        for (int i = 0; i < 6; i++) begin
            g6[5-i] = g_f[NB_G-1-(i % NB_G)];
        end
        for (int i = 0; i < 5; i++) begin
            b5[4-i] = b_f[NB_B-1-(i % NB_B)];
        end
        pix = {r5, g6, b5};
`ifdef FBS_TESTPAT_EN
        if (test_mode) begin
            pix = {{5{bar_idx[2]}}, {6{bar_idx[1]}}, {5{bar_idx[0]}}};
        end
`endif
    end

    // ------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------
    logic hs;
    logic at_last_col;
    logic at_last_row;

    assign hs          = m_valid_q && m_ready;
    assign at_last_col = (out_col_q == LAST_COL);
    assign at_last_row = (out_row_q == LAST_ROW);

    always_comb begin
        state_d      = state_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        row_base_d   = row_base_q;
        fb_addr_d    = fb_addr_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_sof_d      = m_sof_q;
        m_eol_d      = m_eol_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    out_col_d  = '0;
                    out_row_d  = '0;
                    row_base_d = '0;
                    fb_addr_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = READ;
                end
            end

            // Address was registered on the way in; wait for the data.
            READ: begin
                state_d = LATCH;
            end

            LATCH: begin
                m_data_d  = pix;
                m_valid_d = 1'b1;
                m_sof_d   = (out_col_q == '0) && (out_row_q == '0);
                m_eol_d   = at_last_col;
                state_d   = OUT;
            end

            OUT: begin
                if (hs) begin
                    m_valid_d = 1'b0;
                    if (at_last_col && at_last_row) begin
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        if (at_last_col) begin
                            out_col_d  = '0;
                            out_row_d  = out_row_q + 1'b1;
                            row_base_d = row_base_q + ROW_STEP;
                        end else begin
                            out_col_d = out_col_q + 1'b1;
                        end
                        fb_addr_d = row_base_d
                                  + (out_col_d << DECIM_LOG2);
                        state_d   = READ;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            out_col_q    <= '0;
            out_row_q    <= '0;
            row_base_q   <= '0;
            fb_addr_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_sof_q      <= 1'b0;
            m_eol_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            row_base_q   <= row_base_d;
            fb_addr_q    <= fb_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_sof_q      <= m_sof_d;
            m_eol_q      <= m_eol_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign fb_addr    = fb_addr_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_sof      = m_sof_q;
    assign m_eol      = m_eol_q;

endmodule

// File: tb/tb_fb_stream_scaler.sv
// tb_fb_stream_scaler: scoreboard bench for fb_stream_scaler.
// Frame scan, conversion, backpressure, start-while-busy, mid-frame reset.

module tb_fb_stream_scaler;

    localparam int OC = 80;
    localparam int OR = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        m_ready = 1'b1;
    logic        busy;
    logic        frame_done;
    logic [14:0] fb_addr;
    logic [11:0] fb_data = '0;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_sof;
    logic        m_eol;
`ifdef FBS_TESTPAT_EN
    logic        test_mode = 1'b0;
`endif

    fb_stream_scaler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .frame_done(frame_done),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
`ifdef FBS_TESTPAT_EN
        .test_mode (test_mode),
`endif
        .m_data    (m_data),
        .m_sof     (m_sof),
        .m_eol     (m_eol)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame buffer model.
    logic        use_hold = 1'b0;
    logic [11:0] hold = '0;
    always @(posedge clk) begin
        fb_data <= use_hold ? hold : fb_addr[11:0];
    end

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eol;
        logic [14:0] addr;
        logic        last;
    } beat_t;

    beat_t sb[$];
    beat_t e;
    int    n_assert = 0;
    int    n_fail = 0;
    int    beats = 0;
    int    dones = 0;
    logic  prev_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] conv(input logic [11:0] v);
        return {v[11:8], v[11], v[7:4], v[7:6], v[3:0], v[3]};
    endfunction

    // Output monitor: pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) begin
                dones++;
                check("done_follows_last", 32'(prev_last), 32'd1);
                check("busy_low_at_done", 32'(busy), 32'd0);
            end
            prev_last = 1'b0;
            if (m_valid && m_ready) begin
                beats++;
                if (sb.size() == 0) begin
                    check("beat_expected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("m_data", 32'(m_data), 32'(e.data));
                    check("m_sof", 32'(m_sof), 32'(e.sof));
                    check("m_eol", 32'(m_eol), 32'(e.eol));
                    check("fb_addr", 32'(fb_addr), 32'(e.addr));
                    prev_last = e.last;
                end
            end
        end
    end

    task automatic push_frame();
        for (int r = 0; r < OR; r++) begin
            for (int c = 0; c < OC; c++) begin
                beat_t b;
                b.addr = 15'(r * 320 + c * 2);
                b.data = conv(b.addr[11:0]);
                b.sof  = (r == 0) && (c == 0);
                b.eol  = (c == OC - 1);
                b.last = (r == OR - 1) && (c == OC - 1);
                sb.push_back(b);
            end
        end
    endtask

    task automatic start_and_check();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_cycle1", 32'(busy), 32'd1);
        check("addr_cycle1", 32'(fb_addr), 32'd0);
        check("valid_cycle1", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("valid_cycle2", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("valid_cycle3", 32'(m_valid), 32'd1);
    endtask

    task automatic wait_beats(input int n, input int budget,
                              input string tag);
        int k = 0;
        while (beats < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (beats < n) check(tag, 32'(beats), 32'(n));
    endtask

    task automatic wait_done(input int n, input int budget,
                             input string tag);
        int k = 0;
        while (dones < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (dones < n) check(tag, 32'(dones), 32'(n));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("rst_flags",
              32'({busy, frame_done, m_valid, m_sof, m_eol}), 32'd0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        sb.delete();
        beats = 0;
        dones = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [11:0] cv_in[4]  = '{12'hF00, 12'h0F0, 12'h00F, 12'h8A5};
    logic [15:0] cv_out[4] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8D4A};

    initial begin
        logic [15:0] d0;
        logic [14:0] a0;
        logic        s0;
        logic        l0;
        int          b0;
        int          k;

        // Reset state
        #12;
        check("init_flags",
              32'({busy, frame_done, m_valid, m_sof, m_eol}), 32'd0);
        check("init_addr", 32'(fb_addr), 32'd0);
        check("init_data", 32'(m_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full frame with start-while-busy and backpressure
        push_frame();
        start_and_check();
        wait_beats(100, 1000, "timeout_beat100");
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        wait_beats(500, 2000, "timeout_beat500");
        @(posedge clk);
        #1 m_ready = 1'b0;
        k = 0;
        @(negedge clk);
        while (!m_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("bp_valid_seen", 32'(m_valid), 32'd1);
        d0 = m_data;
        a0 = fb_addr;
        s0 = m_sof;
        l0 = m_eol;
        b0 = beats;
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 32'(m_valid), 32'd1);
            check("bp_data", 32'(m_data), 32'(d0));
            check("bp_addr", 32'(fb_addr), 32'(a0));
            check("bp_flags", 32'({m_sof, m_eol}), 32'({s0, l0}));
            check("bp_beats", 32'(beats), 32'(b0));
        end
        @(posedge clk);
        #1 m_ready = 1'b1;

        wait_done(1, 20000, "timeout_frame1");
        repeat (20) @(negedge clk);
        check("frame1_beats", 32'(beats), 32'd4800);
        check("frame1_dones", 32'(dones), 32'd1);
        check("frame1_sb_empty", 32'(sb.size()), 32'd0);
        check("frame1_idle", 32'(busy), 32'd0);

        // Mid-frame reset, then restart from address 0
        do_reset();
        push_frame();
        start_and_check();
        wait_beats(1234, 5000, "timeout_beat1234");
        do_reset();
        check("abort_no_done", 32'(dones), 32'd0);
        push_frame();
        start_and_check();
        wait_done(1, 20000, "timeout_frame2");
        repeat (5) @(negedge clk);
        check("frame2_beats", 32'(beats), 32'd4800);
        check("frame2_dones", 32'(dones), 32'd1);

        // Colour conversion with constant buffer data
        use_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            hold = cv_in[i];
            do_reset();
            b.data = cv_out[i];
            b.sof  = 1'b1;
            b.eol  = 1'b0;
            b.addr = '0;
            b.last = 1'b0;
            sb.push_back(b);
            start_and_check();
            wait_beats(1, 20, "timeout_conv");
            check("conv_sb_empty", 32'(sb.size()), 32'd0);
        end
        use_hold = 1'b0;

`ifdef FBS_TESTPAT_EN
        begin
            logic [15:0] bars[8] = '{16'h0000, 16'h001F, 16'h07E0,
                                     16'h07FF, 16'hF800, 16'hF81F,
                                     16'hFFE0, 16'hFFFF};
            test_mode = 1'b1;
            do_reset();
            for (int c = 0; c < 64; c++) begin
                beat_t b;
                b.data = bars[c / 8];
                b.sof  = (c == 0);
                b.eol  = 1'b0;
                b.addr = 15'(c * 2);
                b.last = 1'b0;
                sb.push_back(b);
            end
            start_and_check();
            wait_beats(64, 400, "timeout_testpat");
            check("tp_sb_empty", 32'(sb.size()), 32'd0);
            test_mode = 1'b0;
        end
`endif

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
